// File: rtl/adder_accumulator.sv
// Packet accumulator: sums a valid/ready operand stream per in_last-delimited
// packet through a ripple-carry chain and holds the total until it is taken.
module adder_accumulator #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SIZE-1:0]  add_sum;
  logic             add_cout;
  logic             accept;
  logic             release_res;

  assign accept      = in_valid & in_ready;
  assign release_res = (state_q == ST_HOLD) & out_ready;

  // Ripple-carry adder chain, carry-in 0
  always_comb begin
    add_sum  = '0;
    add_cout = 1'b0;
    for (int i = 0; i < int'(SIZE); i++) begin
      add_sum[i] = acc_q[i] ^ in_data[i] ^ add_cout;
      add_cout   = (acc_q[i] & in_data[i]) | (add_cout & (acc_q[i] ^ in_data[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Result taken: clear so the next packet starts from zero
        if (release_res) begin
          state_d = ST_ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC) & ~rst;
    out_valid = (state_q == ST_HOLD);
    out_sum   = acc_q;
    out_carry = ovf_q;
    out_count = cnt_q;
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench for adder_accumulator: driver pushes expected packet totals,
// a negedge monitor pops and compares on each output handshake.
module tb_adder_accumulator;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned CNT_W = 2;
  localparam int MODV   = 1 << SIZE;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] out_count;

  adder_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int carry;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 2;  // 0 random, 1 forced low, 2 forced high

  // Reference model: plain integer arithmetic over the accepted beats
  int m_sum   = 0;
  int m_carry = 0;
  int m_cnt   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_clear();
    m_sum = 0; m_carry = 0; m_cnt = 0;
  endfunction

  function automatic void model_beat(int d, bit last);
    exp_t e;
    int t;
    t = m_sum + d;
    if (t >= MODV) m_carry = 1;
    m_sum = t % MODV;
    if (m_cnt < CNTMAX) m_cnt++;
    if (last) begin
      e.sum = m_sum; e.carry = m_carry; e.cnt = m_cnt;
      q.push_back(e);
      model_clear();
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(int d, bit last, bit chk_lat);
    int  waitc;
    bit  done;
    waitc = 0;
    done  = 1'b0;
    in_valid = 1'b1;
    in_data  = SIZE'(d);
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        model_beat(d, last);
      end else if (++waitc > 200) begin
        check("accept_timeout", 0, 1);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (chk_lat && last) begin
      @(negedge clk);
      check("last_to_valid", int'(out_valid), 1);
      step();
    end
  endtask

  task automatic do_reset(int n, bit hold_valid);
    rst      = 1'b1;
    in_valid = hold_valid;
    in_data  = SIZE'(9);
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        q.delete();
        model_clear();
      end
      check("rst_in_ready", int'(in_ready), 0);
      if (i > 0) check("rst_out_valid", int'(out_valid), 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_sum", int'(out_sum), 0);
    check("post_rst_count", int'(out_count), 0);
    check("post_rst_carry", int'(out_carry), 0);
    step();
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = (rdy_mode == 0) ? 1'($urandom % 2) : (rdy_mode == 2);
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on handshake
  exp_t             mon_e;
  bit               hold_prev = 1'b0;
  logic [SIZE-1:0]  prev_sum;
  logic             prev_carry;
  logic [CNT_W-1:0] prev_count;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("in_ready_vs_valid", int'(in_ready), int'(!out_valid));
      if (out_valid && hold_prev) begin
        check("hold_sum_stable", int'(out_sum), int'(prev_sum));
        check("hold_carry_stable", int'(out_carry), int'(prev_carry));
        check("hold_count_stable", int'(out_count), int'(prev_count));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("sum", int'(out_sum), mon_e.sum);
          check("carry", int'(out_carry), mon_e.carry);
          check("count", int'(out_count), mon_e.cnt);
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev  = out_valid;
        prev_sum   = out_sum;
        prev_carry = out_carry;
        prev_count = out_count;
      end
    end
  end

  initial begin
    int len;
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    step();

    // Reset with in_valid held high
    do_reset(2, 1'b1);

    // Basic packet and overflow
    send(3, 1'b0, 1'b0);
    send(4, 1'b0, 1'b0);
    send(5, 1'b1, 1'b1);
    idle(2);
    send(15, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0);
    send(2, 1'b1, 1'b1);
    send(1, 1'b1, 1'b1);
    idle(2);

    // Backpressure: result held while upstream toggles in_valid
    rdy_mode = 1;
    send(6, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      in_data  = SIZE'(9);
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum", int'(out_sum), 6);
      check("bp_count", int'(out_count), 1);
      check("bp_carry", int'(out_carry), 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rdy_mode = 2;
    step();
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    step();
    send(2, 1'b1, 1'b1);
    idle(2);

    // Gaps between beats and beat-count saturation
    for (int k = 0; k < 5; k++) begin
      send(1, k == 4, k == 4);
      if (k != 4) idle(2);
    end
    idle(2);

    // Reset mid-packet, then reset while a result is held
    send(7, 1'b0, 1'b0);
    send(7, 1'b0, 1'b0);
    do_reset(1, 1'b0);
    send(1, 1'b1, 1'b1);
    idle(2);
    rdy_mode = 1;
    send(4, 1'b1, 1'b1);
    idle(2);
    do_reset(1, 1'b0);
    rdy_mode = 2;
    idle(3);

    // Randomized packets with random backpressure and gaps
    rdy_mode = 0;
    repeat (40) begin
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        send(int'($urandom % MODV), j == len - 1, 1'b0);
        if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    rdy_mode = 2;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      step();
      w++;
    end
    check("drain_empty", q.size(), 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
Sequential stage that sits directly upstream of the adder consumers. It takes a stream of SIZE-bit operands over a valid/ready handshake, sums each packet through an internal SIZE-bit ripple-carry adder chain, and presents the packet total on a valid/ready output. Packets are delimited by in_last. The block is the first registered, flow-controlled arithmetic stage in the datapath.

Parameters:
SIZE, 4, operand and sum width in bits (>= 2)
CNT_W, 4, width of the beat counter reported with each result

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat offered
in_ready  output  1  block can accept a beat this cycle
in_data  input  SIZE  operand
in_last  input  1  beat is the final beat of the packet
out_valid  output  1  packet result available
out_ready  input  1  downstream accepts the result
out_sum  output  SIZE  packet sum modulo 2^SIZE
out_carry  output  1  sticky: any carry-out of the MSB occurred during the packet
out_count  output  CNT_W  number of beats in the packet, saturating

Behaviour:
- Internal state: acc[SIZE-1:0], ovf, cnt[CNT_W-1:0], and a 2-state FSM {ACC, HOLD}.
- Reset (rst high at a clock edge): state becomes ACC, and acc, ovf, cnt and out_valid are all cleared to 0. While rst is high, in_ready=0. in_ready=1 on the first cycle after rst deasserts.
- in_ready = (state==ACC) & !rst, decoded combinationally from registered state. out_valid is registered and equals (state==HOLD).
- ACC state, beat accepted (in_valid & in_ready at a clock edge):
  - {c, s} = acc + in_data, computed by the SIZE-bit adder chain with carry-in 0.
  - acc <= s.
  - ovf <= ovf | c.
  - cnt <= cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - If in_last is set: the updated values are latched and state goes to HOLD. out_valid=1 on the next cycle, and that result includes the last beat.
- ACC state, in_valid=0: no change. in_data and in_last are ignored (don't-care).
- HOLD state:
  - in_ready=0. Beats offered with in_valid are not accepted and are not lost by the block; the upstream must hold them.
  - out_sum=acc, out_carry=ovf, out_count=cnt, all stable until the handshake.
- Output handshake (out_valid & out_ready at a clock edge): acc, ovf and cnt clear to 0, and state returns to ACC. in_ready=1 on the following cycle. There is no same-cycle bypass, so minimum result-to-next-accept spacing is 1 cycle.
- out_ready while out_valid=0 has no effect.
- Throughput: one beat per cycle in ACC. Per packet, the overhead is 1 HOLD cycle minimum plus any backpressure cycles.
- Single-beat packet (in_last on the first beat): result = that operand, count = 1, carry = 0.
- Zero-beat packets are impossible, because in_last is only sampled on an accepted beat.
- Reset mid-packet: the partial sum is discarded and the next packet starts from 0.
- Reset in HOLD: the pending result is dropped and out_valid=0 next cycle.
- rst has priority over every handshake in the same cycle.
- out_sum, out_carry and out_count are don't-care while out_valid=0. They are driven from acc/ovf/cnt and read 0 after reset.

Test Plan:
1. Reset: hold rst high for 2 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; in_ready=1 on the first cycle after rst falls; out_sum=0, out_count=0.
2. Basic packet (SIZE=4): beats 3, 4, 5(last) on consecutive cycles -> out_valid=1 on the cycle after the last beat, with out_sum=12, out_carry=0, out_count=3.
3. Overflow: beats 15, 1, 2(last) -> out_sum=2, out_carry=1, out_count=3. The next packet 1(last) -> out_sum=1, out_carry=0, confirming the sticky flag clears.
4. Backpressure: after packet 6(last), hold out_ready=0 for 5 cycles while toggling in_valid -> out_valid stays 1, outputs stay 6/0/1, in_ready=0, nothing is accepted. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle; packet 2(last) then yields out_sum=2.
5. Gaps and saturation (CNT_W=2): send five beats of 1 with idle cycles in between, last on the fifth -> out_sum=5, out_count=3 (saturated), out_carry=0.
6. Reset mid-packet and in HOLD: beats 7, 7, then rst for 1 cycle, then 1(last) -> out_sum=1, out_count=1, out_carry=0. Assert rst during HOLD -> out_valid=0 the next cycle and no result is delivered.
